// File: rtl/simple_dpram_sync.sv
// Simple dual-port RAM: one synchronous write port and one read port with a registered read.
// Ports: i_clk clock; i_wr_en/i_wr_addr/i_wr_data write port; i_rd_addr read address;
//        o_rd_data is the word at i_rd_addr as sampled on the previous rising edge.
// A read of the address being written on the same edge returns the old contents.
module simple_dpram_sync #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Storage array and registered read; contents are never reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_fwft_prog.sv
// First-word fall-through FIFO with programmable almost-full/almost-empty thresholds,
// an occupancy count and sticky overflow/underflow flags.
// Ports: clk, rst (synchronous, active-high); din/wr_en/full write side; dout/rd_en/empty
//        read side (dout valid whenever empty=0); af_thresh/ae_thresh thresholds and
//        almost_full/almost_empty flags; count occupancy 0..DEPTH; overflow/underflow
//        sticky error flags cleared by clr_flags.
module fifo_fwft_prog #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DEPTH_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   wr_en,
    output logic                   full,
    output logic [DATA_WIDTH-1:0]  dout,
    input  logic                   rd_en,
    output logic                   empty,
    input  logic [DEPTH_WIDTH:0]   af_thresh,
    input  logic [DEPTH_WIDTH:0]   ae_thresh,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [DEPTH_WIDTH:0]   count,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   clr_flags
);

    localparam int unsigned PW = DEPTH_WIDTH;
    localparam int unsigned CW = DEPTH_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(1) << DEPTH_WIDTH;

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almost_full;
    logic                  r_almost_empty;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_byp_sel;
    logic [DATA_WIDTH-1:0] r_byp_data;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [PW-1:0]         w_wr_ptr_nxt;
    logic [PW-1:0]         w_rd_ptr_nxt;
    logic [CW-1:0]         w_count_nxt;
    logic                  w_collide;
    logic                  w_ram_we;
    logic [DATA_WIDTH-1:0] w_ram_q;

    // Accept/pointer/count next-state logic.
    always_comb begin
        w_wr_acc     = wr_en & ~r_full;
        w_rd_acc     = rd_en & ~r_empty;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (w_wr_acc) begin
            w_wr_ptr_nxt = r_wr_ptr + PW'(1);
        end
        if (w_rd_acc) begin
            w_rd_ptr_nxt = r_rd_ptr + PW'(1);
        end
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - CW'(1);
        end
        // The head word after this edge is the one being written now, so the RAM
        // read (old contents) would be stale; capture it from din instead.
        w_collide = w_wr_acc && (r_wr_ptr == w_rd_ptr_nxt);
        w_ram_we  = w_wr_acc & ~rst;
    end

    // The RAM re-reads the next head address every edge, so its read register
    // always holds the prefetched head word except right after a collision.
    simple_dpram_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (PW)
    ) u_ram (
        .i_clk     (clk),
        .i_wr_en   (w_ram_we),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (din),
        .i_rd_addr (w_rd_ptr_nxt),
        .o_rd_data (w_ram_q)
    );

    // Pointers, count, status flags and output bypass register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= (af_thresh == '0);
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_byp_sel      <= 1'b0;
            r_byp_data     <= '0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == DEPTH_CNT);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= af_thresh);
            r_almost_empty <= (w_count_nxt <= ae_thresh);
            r_byp_sel      <= w_collide;
            if (w_collide) begin
                r_byp_data <= din;
            end
            // Set events win over a simultaneous clear.
            if (wr_en && r_full) begin
                r_overflow <= 1'b1;
            end else if (clr_flags) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && r_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_flags) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign dout         = r_byp_sel ? r_byp_data : w_ram_q;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_fwft_prog.sv
// Directed bench for fifo_fwft_prog: writes push expected words into a queue, a
// monitor pops and compares dout whenever a read is presented to a non-empty FIFO.
module tb_fifo_fwft_prog;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;

    logic          clk;
    logic          rst;
    logic [DW-1:0] din;
    logic          wr_en;
    logic          full;
    logic [DW-1:0] dout;
    logic          rd_en;
    logic          empty;
    logic [AW:0]   af_thresh;
    logic [AW:0]   ae_thresh;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic          clr_flags;

    int vectors;
    int miscompares;
    logic [DW-1:0] exp_q[$];

    fifo_fwft_prog #(
        .DATA_WIDTH  (DW),
        .DEPTH_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .wr_en        (wr_en),
        .full         (full),
        .dout         (dout),
        .rd_en        (rd_en),
        .empty        (empty),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_flags    (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; push marks a write the FIFO must accept.
    task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d,
                       input logic push, input logic clr);
        wr_en     = w;
        rd_en     = r;
        din       = d;
        clr_flags = clr;
        if (push) exp_q.push_back(d);
        @(posedge clk);
        #1;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        clr_flags = 1'b0;
    endtask

    // Read-data monitor: a read presented to a non-empty FIFO pops the head word.
    always @(negedge clk) begin
        if (!rst && rd_en && !empty) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL read_data: popped 0x%0h, expected no word at %0t", dout, $time);
            end else begin
                check("read_data", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        din         = '0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        clr_flags   = 1'b0;
        af_thresh   = 5'd0;
        ae_thresh   = 5'd3;
        @(posedge clk);
        @(posedge clk);
        #1;
        // Reset state, with af_thresh=0 forcing almost_full
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_almost_full", 32'(almost_full), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        rst = 1'b0;

        af_thresh = 5'd12;
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("af_thresh_change", 32'(almost_full), 32'd0);

        // Fill 0x0001..0x0010 with threshold tracking
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 1'b0, DW'(k), 1'b1, 1'b0);
            check("fill_count", 32'(count), 32'(k));
            check("fill_almost_empty", 32'(almost_empty), 32'(k <= 3));
            check("fill_almost_full", 32'(almost_full), 32'(k >= 12));
            if (k == 1) begin
                check("first_word_empty", 32'(empty), 32'd0);
                check("first_word_dout", 32'(dout), 32'h0001);
            end
        end
        check("full_flag", 32'(full), 32'd1);
        check("full_not_empty", 32'(empty), 32'd0);

        // Overflow, clear priority, write refused even with a read
        cyc(1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_head_kept", 32'(dout), 32'h0001);
        cyc(1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b1);
        check("ovf_set_beats_clr", 32'(overflow), 32'd1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("ovf_clr", 32'(overflow), 32'd0);
        cyc(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        check("full_rdwr_count", 32'(count), 32'd15);
        check("full_rdwr_ovf", 32'(overflow), 32'd1);
        check("full_rdwr_full", 32'(full), 32'd0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("ovf_clr2", 32'(overflow), 32'd0);

        for (int k = 15; k >= 1; k--) begin
            cyc(1'b0, 1'b1, '0, 1'b0, 1'b0);
            check("drain_count", 32'(count), 32'(k - 1));
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_almost_empty", 32'(almost_empty), 32'd1);

        // Underflow and clear
        cyc(1'b0, 1'b1, '0, 1'b0, 1'b0);
        check("unf_set", 32'(underflow), 32'd1);
        check("unf_count", 32'(count), 32'd0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("unf_clr", 32'(underflow), 32'd0);

        // Single word fall-through, no read issued
        cyc(1'b1, 1'b0, 16'hA5A5, 1'b1, 1'b0);
        check("fwft_empty", 32'(empty), 32'd0);
        check("fwft_dout", 32'(dout), 32'hA5A5);
        check("fwft_count", 32'(count), 32'd1);
        cyc(1'b0, 1'b1, '0, 1'b0, 1'b0);
        check("fwft_pop_empty", 32'(empty), 32'd1);

        // Refused read with simultaneous write into empty FIFO
        cyc(1'b1, 1'b1, 16'h5A5A, 1'b1, 1'b0);
        check("unf_wr_flag", 32'(underflow), 32'd1);
        check("unf_wr_count", 32'(count), 32'd1);
        check("unf_wr_dout", 32'(dout), 32'h5A5A);
        cyc(1'b0, 1'b1, '0, 1'b0, 1'b1);
        check("unf_wr_clr", 32'(underflow), 32'd0);
        check("unf_wr_empty", 32'(empty), 32'd1);

        // Steady state at count=8 across pointer wrap
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, DW'(16'h0100 + i), 1'b1, 1'b0);
        check("steady_fill", 32'(count), 32'd8);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b1, DW'(16'h0200 + i), 1'b1, 1'b0);
            check("steady_count", 32'(count), 32'd8);
        end
        check("steady_ovf", 32'(overflow), 32'd0);
        check("steady_unf", 32'(underflow), 32'd0);
        check("steady_full", 32'(full), 32'd0);
        check("steady_empty", 32'(empty), 32'd0);
        check("steady_af", 32'(almost_full), 32'd0);
        check("steady_ae", 32'(almost_empty), 32'd0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, '0, 1'b0, 1'b0);
        check("steady_drain_empty", 32'(empty), 32'd1);

        // Threshold extremes
        af_thresh = 5'd0;
        ae_thresh = 5'd0;
        cyc(1'b1, 1'b0, 16'h0042, 1'b1, 1'b0);
        check("af_zero", 32'(almost_full), 32'd1);
        check("ae_zero_count1", 32'(almost_empty), 32'd0);
        ae_thresh = 5'd16;
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("ae_depth", 32'(almost_empty), 32'd1);
        af_thresh = 5'd12;
        ae_thresh = 5'd3;
        cyc(1'b0, 1'b1, '0, 1'b0, 1'b0);
        check("thr_restore_af", 32'(almost_full), 32'd0);

        // Reset mid-operation at count=9, write ignored
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, DW'(16'h0300 + i), 1'b1, 1'b0);
        check("pre_rst_count", 32'(count), 32'd9);
        rst   = 1'b1;
        wr_en = 1'b1;
        din   = 16'hFFFF;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        exp_q.delete();
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_full", 32'(full), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_unf", 32'(underflow), 32'd0);
        check("mid_rst_ae", 32'(almost_empty), 32'd1);
        cyc(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0);
        check("post_rst_dout", 32'(dout), 32'h1234);
        check("post_rst_count", 32'(count), 32'd1);
        cyc(1'b0, 1'b1, '0, 1'b0, 1'b0);
        check("post_rst_empty", 32'(empty), 32'd1);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
